// File: rtl/ds_deframer_pkg.sv
// Shared types for the serial deframer: FSM states and the default sync word.
package ds_deframer_pkg;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2
    } state_t;

    localparam logic [7:0] DS_SYNC_DEFAULT = 8'hA5;

endpackage

// File: rtl/ds_deframer_outreg.sv
// One-entry valid/ready holding register with drop detection, sticky overflow
// and a count of accepted words.
module ds_deframer_outreg #(
    parameter int unsigned W     = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [W-1:0]     load_data,
    input  logic             ready,
    input  logic             ovf_clr,
    output logic [W-1:0]     data,
    output logic             valid,
    output logic             ovf,
    output logic [CNT_W-1:0] cnt
);

    logic accept_c;

    // A pop in the same cycle frees the slot, so load and pop can overlap.
    assign accept_c = !valid || ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data  <= '0;
            valid <= 1'b0;
            ovf   <= 1'b0;
            cnt   <= '0;
        end else begin
            if (load && accept_c) begin
                data  <= load_data;
                valid <= 1'b1;
                cnt   <= cnt + 1'b1;
            end else if (valid && ready) begin
                valid <= 1'b0;
            end

            // A drop in the same cycle as a clear keeps the flag set.
            if (load && !accept_c) begin
                ovf <= 1'b1;
            end else if (ovf_clr) begin
                ovf <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/ds_serial_deframer.sv
// Serial frame receiver: hunts for a sync word, deserialises the payload and
// hands it to a valid/ready holding register. DS_DEFRAMER_PARITY_EN adds an
// even-parity bit after the payload and a par_err output.
module ds_serial_deframer
    import ds_deframer_pkg::*;
#(
    parameter int unsigned       DATA_W       = 8,
    parameter int unsigned       SYNC_W       = 8,
    parameter logic [SYNC_W-1:0] SYNC_PATTERN = SYNC_W'(DS_SYNC_DEFAULT),
    parameter int unsigned       CNT_W        = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              din,
    output logic [DATA_W-1:0] dout_data,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic              in_frame,
    output logic              ovf,
    input  logic              ovf_clr,
    output logic [CNT_W-1:0]  frame_cnt
`ifdef DS_DEFRAMER_PARITY_EN
    ,
    output logic              par_err
`endif
);

    localparam int unsigned FILL_W = $clog2(SYNC_W + 1);
    localparam int unsigned BCNT_W = $clog2(DATA_W);
`ifdef DS_DEFRAMER_PARITY_EN
    localparam int unsigned WORD_W = DATA_W + 1;
`else
    localparam int unsigned WORD_W = DATA_W;
`endif

    state_t              state_q, state_d;
    logic [SYNC_W-1:0]   sync_sr_q, sync_sr_d, sync_shift_c;
    logic [FILL_W-1:0]   fill_q, fill_d, fill_inc_c;
    logic [DATA_W-1:0]   data_sr_q, data_sr_d;
    logic [BCNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic                done_q, done_d;
    logic                perr_q, perr_d;
    logic [WORD_W-1:0]   word_in_c;
    logic [WORD_W-1:0]   word_q;

    assign sync_shift_c = {sync_sr_q[SYNC_W-2:0], din};
    assign fill_inc_c   = (fill_q == FILL_W'(SYNC_W)) ? fill_q : fill_q + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= HUNT;
            sync_sr_q <= '0;
            fill_q    <= '0;
            data_sr_q <= '0;
            bit_cnt_q <= '0;
            done_q    <= 1'b0;
            perr_q    <= 1'b0;
            in_frame  <= 1'b0;
        end else begin
            state_q   <= state_d;
            sync_sr_q <= sync_sr_d;
            fill_q    <= fill_d;
            data_sr_q <= data_sr_d;
            bit_cnt_q <= bit_cnt_d;
            done_q    <= done_d;
            perr_q    <= perr_d;
            in_frame  <= (state_d == DATA);
        end
    end

    always_comb begin
        state_d   = state_q;
        sync_sr_d = sync_sr_q;
        fill_d    = fill_q;
        data_sr_d = data_sr_q;
        bit_cnt_d = bit_cnt_q;
        done_d    = 1'b0;
        perr_d    = perr_q;

        case (state_q)
            HUNT: begin
                sync_sr_d = sync_shift_c;
                fill_d    = fill_inc_c;
                if (fill_inc_c == FILL_W'(SYNC_W) && sync_shift_c == SYNC_PATTERN) begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                end
            end
            DATA: begin
                data_sr_d = {data_sr_q[DATA_W-2:0], din};
                bit_cnt_d = bit_cnt_q + 1'b1;
                if (bit_cnt_q == BCNT_W'(DATA_W - 1)) begin
                    // Empty the sync window so payload bits can never lock.
                    bit_cnt_d = '0;
                    fill_d    = '0;
`ifdef DS_DEFRAMER_PARITY_EN
                    state_d   = PARITY;
`else
                    state_d   = HUNT;
                    done_d    = 1'b1;
`endif
                end
            end
`ifdef DS_DEFRAMER_PARITY_EN
            PARITY: begin
                state_d = HUNT;
                done_d  = 1'b1;
                perr_d  = ^{data_sr_q, din};
            end
`endif
            default: begin
                state_d = HUNT;
            end
        endcase
    end

`ifdef DS_DEFRAMER_PARITY_EN
    assign word_in_c = {perr_q, data_sr_q};
    assign par_err   = word_q[DATA_W];
`else
    assign word_in_c = data_sr_q;
`endif
    assign dout_data = word_q[DATA_W-1:0];

    ds_deframer_outreg #(
        .W     (WORD_W),
        .CNT_W (CNT_W)
    ) u_outreg (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (done_q),
        .load_data (word_in_c),
        .ready     (dout_ready),
        .ovf_clr   (ovf_clr),
        .data      (word_q),
        .valid     (dout_valid),
        .ovf       (ovf),
        .cnt       (frame_cnt)
    );

endmodule

// File: tb/tb_ds_serial_deframer.sv
// Directed bench for ds_serial_deframer; honours DS_DEFRAMER_PARITY_EN.
module tb_ds_serial_deframer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        din;
    logic [7:0]  dout_data;
    logic        dout_valid;
    logic        dout_ready;
    logic        in_frame;
    logic        ovf;
    logic        ovf_clr;
    logic [15:0] frame_cnt;
`ifdef DS_DEFRAMER_PARITY_EN
    logic        par_err;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int inf_cnt  = 0;

    always #5 clk = ~clk;

    ds_serial_deframer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .dout_data  (dout_data),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .in_frame   (in_frame),
        .ovf        (ovf),
        .ovf_clr    (ovf_clr),
        .frame_cnt  (frame_cnt)
`ifdef DS_DEFRAMER_PARITY_EN
        ,
        .par_err    (par_err)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to the next falling edge, counting cycles spent in DATA.
    task automatic tick();
        @(negedge clk);
        if (in_frame) inf_cnt++;
    endtask

    task automatic send_bit(input logic b);
        tick();
        din = b;
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic send_frame(input logic [7:0] p, input logic flip);
        send_byte(8'hA5);
        send_byte(p);
`ifdef DS_DEFRAMER_PARITY_EN
        send_bit(^p ^ flip);
`else
        if (flip) $display("note: parity flip ignored in this build");
`endif
    endtask

    // Falling edge after the last frame bit has been sampled.
    task automatic frame_end();
        tick();
        din = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        rst_n      = 1'b0;
        din        = 1'b0;
        dout_ready = 1'b0;
        ovf_clr    = 1'b0;
        repeat (3) @(negedge clk);
        check("rst valid", 32'(dout_valid), 32'd0);
        check("rst data", 32'(dout_data), 32'h00);
        check("rst in_frame", 32'(in_frame), 32'd0);
        check("rst ovf", 32'(ovf), 32'd0);
        check("rst cnt", 32'(frame_cnt), 32'd0);
        rst_n = 1'b1;

        // Basic frame, latency and in_frame width.
        inf_cnt = 0;
        send_frame(8'h3C, 1'b0);
        frame_end();
        check("t1 valid before load", 32'(dout_valid), 32'd0);
        check("t1 in_frame after", 32'(in_frame), 32'd0);
        tick();
        check("t1 valid", 32'(dout_valid), 32'd1);
        check("t1 data", 32'(dout_data), 32'h3C);
        check("t1 cnt", 32'(frame_cnt), 32'd1);
        check("t1 in_frame cycles", 32'(inf_cnt), 32'd8);
`ifdef DS_DEFRAMER_PARITY_EN
        check("t1 par_err", 32'(par_err), 32'd0);
`endif
        dout_ready = 1'b1;
        tick();
        check("t1 pop valid", 32'(dout_valid), 32'd0);
        check("t1 pop data held", 32'(dout_data), 32'h3C);
        dout_ready = 1'b0;

        // Partial pattern prefix must not lock early.
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_frame(8'h81, 1'b0);
        frame_end();
        tick();
        check("t2 valid", 32'(dout_valid), 32'd1);
        check("t2 data", 32'(dout_data), 32'h81);
        check("t2 cnt", 32'(frame_cnt), 32'd2);
        dout_ready = 1'b1;
        tick();
        dout_ready = 1'b0;
        repeat (20) tick();
        check("t2 once valid", 32'(dout_valid), 32'd0);
        check("t2 once cnt", 32'(frame_cnt), 32'd2);

        // Sync-like payload is data; an unsynced byte is ignored.
        dout_ready = 1'b1;
        send_frame(8'hA5, 1'b0);
        frame_end();
        tick();
        check("t3 valid", 32'(dout_valid), 32'd1);
        check("t3 data", 32'(dout_data), 32'hA5);
        check("t3 cnt", 32'(frame_cnt), 32'd3);
        tick();
        check("t3 popped", 32'(dout_valid), 32'd0);
        inf_cnt = 0;
        send_byte(8'h3C);
        frame_end();
        repeat (3) tick();
        check("t3 nosync valid", 32'(dout_valid), 32'd0);
        check("t3 nosync cnt", 32'(frame_cnt), 32'd3);
        check("t3 nosync in_frame", 32'(inf_cnt), 32'd0);

        // Overflow: second word dropped while the first waits.
        dout_ready = 1'b0;
        send_frame(8'h11, 1'b0);
        frame_end();
        tick();
        check("t4 first data", 32'(dout_data), 32'h11);
        check("t4 first cnt", 32'(frame_cnt), 32'd4);
        check("t4 first ovf", 32'(ovf), 32'd0);
        send_frame(8'h22, 1'b0);
        frame_end();
        tick();
        check("t4 drop ovf", 32'(ovf), 32'd1);
        check("t4 drop data", 32'(dout_data), 32'h11);
        check("t4 drop valid", 32'(dout_valid), 32'd1);
        check("t4 drop cnt", 32'(frame_cnt), 32'd4);
        ovf_clr    = 1'b1;
        dout_ready = 1'b1;
        tick();
        check("t4 clr ovf", 32'(ovf), 32'd0);
        check("t4 clr valid", 32'(dout_valid), 32'd0);
        ovf_clr    = 1'b0;
        dout_ready = 1'b0;

        // Same-cycle pop and load.
        send_frame(8'h55, 1'b0);
        frame_end();
        tick();
        check("t5 first data", 32'(dout_data), 32'h55);
        check("t5 first cnt", 32'(frame_cnt), 32'd5);
        send_frame(8'hAA, 1'b0);
        frame_end();
        check("t5 order data", 32'(dout_data), 32'h55);
        check("t5 order valid", 32'(dout_valid), 32'd1);
        dout_ready = 1'b1;
        tick();
        check("t5 nobubble valid", 32'(dout_valid), 32'd1);
        check("t5 nobubble data", 32'(dout_data), 32'hAA);
        check("t5 nobubble cnt", 32'(frame_cnt), 32'd6);
        check("t5 nobubble ovf", 32'(ovf), 32'd0);
        tick();
        check("t5 drained", 32'(dout_valid), 32'd0);
        dout_ready = 1'b0;

        // Reset mid-payload discards the partial word.
        send_byte(8'hA5);
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        tick();
        check("t6 in_frame pre", 32'(in_frame), 32'd1);
        rst_n = 1'b0;
        #1;
        check("t6 rst in_frame", 32'(in_frame), 32'd0);
        check("t6 rst data", 32'(dout_data), 32'h00);
        check("t6 rst cnt", 32'(frame_cnt), 32'd0);
        check("t6 rst valid", 32'(dout_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b0);
        frame_end();
        repeat (3) tick();
        check("t6 no stale valid", 32'(dout_valid), 32'd0);
        check("t6 no stale cnt", 32'(frame_cnt), 32'd0);
        send_frame(8'h3C, 1'b0);
        frame_end();
        tick();
        check("t6 recover data", 32'(dout_data), 32'h3C);
        check("t6 recover cnt", 32'(frame_cnt), 32'd1);

`ifdef DS_DEFRAMER_PARITY_EN
        dout_ready = 1'b1;
        tick();
        dout_ready = 1'b0;
        send_frame(8'h3C, 1'b1);
        frame_end();
        tick();
        check("t7 par_err", 32'(par_err), 32'd1);
        check("t7 data", 32'(dout_data), 32'h3C);
        check("t7 valid", 32'(dout_valid), 32'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
